// File: rtl/pipe_adapter_pkg.sv
// Shared sizing helpers and types for the credit adapter and its result FIFO.
// Optional bypass path is selected by PIPE_ADAPTER_BYPASS_EN.
package pipe_adapter_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned CNT_W         = cnt_width(DEPTH_DEFAULT);
  localparam int unsigned PTR_W         = ptr_width(DEPTH_DEFAULT);

  typedef logic [CNT_W-1:0] credit_t;
  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/pipe_credit_adapter_result_fifo.sv
// Circular result buffer; occupancy count separates full from empty.
// A push while full is dropped and latches the sticky ovf flag.
module result_fifo
  import pipe_adapter_pkg::*;
#(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [OUT_W-1:0] push_data,
  input  logic             pop,
  output logic [OUT_W-1:0] head,
  output logic             empty,
  output logic             ovf
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULLC);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_credit_adapter.sv
// Credit-based valid/ready wrapper around a fixed-latency valid-only pipe.
// Define PIPE_ADAPTER_BYPASS_EN for a 0-cycle result path when the FIFO is empty.
module pipe_credit_adapter
  import pipe_adapter_pkg::*;
#(
  parameter int unsigned IN_W  = 96,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [IN_W-1:0]  up_data,
  output logic             pipe_vld,
  output logic [IN_W-1:0]  pipe_data,
  input  logic             ret_vld,
  input  logic [OUT_W-1:0] ret_data,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [OUT_W-1:0] down_data,
  output logic             ovf
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] INIT_CREDIT = CW'(DEPTH);

  logic [CW-1:0]    credit;
  logic             fire_in;
  logic             fire_out;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_head;

  assign up_rdy    = (credit != '0) && !rst;
  assign fire_in   = up_vld && up_rdy;
  assign pipe_vld  = fire_in;
  assign pipe_data = up_data;

`ifdef PIPE_ADAPTER_BYPASS_EN
  // A result arriving at an empty FIFO goes straight out; it is stored only if not taken.
  logic bypass;
  assign bypass    = fifo_empty && ret_vld;
  assign down_vld  = !fifo_empty || ret_vld;
  assign down_data = fifo_empty ? ret_data : fifo_head;
  assign fifo_push = ret_vld && !(bypass && down_rdy);
`else
  assign down_vld  = !fifo_empty;
  assign down_data = fifo_head;
  assign fifo_push = ret_vld;
`endif

  assign fire_out = down_vld && down_rdy;
  assign fifo_pop = fire_out && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= INIT_CREDIT;
    end else if (fire_in && !fire_out) begin
      credit <= credit - CW'(1);
    end else if (fire_out && !fire_in) begin
      credit <= credit + CW'(1);
    end
  end

  result_fifo #(
    .OUT_W (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ret_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .ovf       (ovf)
  );

endmodule
